// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cacheline memory arbiter: FSM states, grant sides and the line type.
package cacheline_mem_arbiter_pkg;

   typedef logic [255:0] rv32i_line;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_GRANT_I,
      ARB_GRANT_D,
      ARB_RESP_I,
      ARB_RESP_D
   } arb_state_t;

   typedef enum logic {
      ARB_SIDE_I,
      ARB_SIDE_D
   } arb_side_t;

endpackage

// File: rtl/cacheline_mem_arbiter_rr_pick2.sv
// Two-way round-robin chooser: a lone requester wins, a tie goes to the side not served last.
module cacheline_mem_arbiter_rr_pick2 (
   input  logic ireq_i,
   input  logic dreq_i,
   input  logic last_d_i,
   output logic pick_d_o
);

   assign pick_d_o = (ireq_i && dreq_i) ? !last_d_i : dreq_i;

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares one physical-memory port between I-cache and D-cache line misses, one transaction at a time.
module cacheline_mem_arbiter
   import cacheline_mem_arbiter_pkg::*;
#(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_addr,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   output logic [CNT_W-1:0]  i_grant_cnt,
   output logic [CNT_W-1:0]  d_grant_cnt
);

   arb_state_t        state_q, state_d;
   arb_side_t         last_q, last_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] i_line_q, i_line_d;
   logic [LINE_W-1:0] d_line_q, d_line_d;
   logic              wr_q, wr_d;
   logic [CNT_W-1:0]  i_cnt_q, i_cnt_d;
   logic [CNT_W-1:0]  d_cnt_q, d_cnt_d;
   logic              d_req;
   logic              pick_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign d_req = d_read | d_write;

   cacheline_mem_arbiter_rr_pick2 u_pick (
      .ireq_i   (i_read),
      .dreq_i   (d_req),
      .last_d_i (last_q == ARB_SIDE_D),
      .pick_d_o (pick_d)
   );

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wr_d     = wr_q;
      i_line_d = i_line_q;
      d_line_d = d_line_q;
      i_cnt_d  = i_cnt_q;
      d_cnt_d  = d_cnt_q;
      case (state_q)
         ARB_IDLE: begin
            if (i_read || d_req) begin
               if (pick_d) begin
                  state_d = ARB_GRANT_D;
                  last_d  = ARB_SIDE_D;
                  addr_d  = d_addr;
                  wdata_d = d_wdata;
                  wr_d    = d_write;   // read+write together resolves to a writeback
                  d_cnt_d = sat_inc(d_cnt_q);
               end else begin
                  state_d = ARB_GRANT_I;
                  last_d  = ARB_SIDE_I;
                  addr_d  = i_addr;
                  wr_d    = 1'b0;
                  i_cnt_d = sat_inc(i_cnt_q);
               end
            end
         end
         ARB_GRANT_I: begin
            if (pmem_resp) begin
               i_line_d = pmem_rdata;
               state_d  = ARB_RESP_I;
            end
         end
         ARB_GRANT_D: begin
            if (pmem_resp) begin
               d_line_d = pmem_rdata;
               state_d  = ARB_RESP_D;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         last_q   <= ARB_SIDE_I;
         addr_q   <= '0;
         wdata_q  <= '0;
         wr_q     <= 1'b0;
         i_line_q <= '0;
         d_line_q <= '0;
         i_cnt_q  <= '0;
         d_cnt_q  <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wr_q     <= wr_d;
         i_line_q <= i_line_d;
         d_line_q <= d_line_d;
         i_cnt_q  <= i_cnt_d;
         d_cnt_q  <= d_cnt_d;
      end
   end

   // Memory strobes decode straight from the state register so an async reset drops them at once.
   assign pmem_read   = (state_q == ARB_GRANT_I) || ((state_q == ARB_GRANT_D) && !wr_q);
   assign pmem_write  = (state_q == ARB_GRANT_D) && wr_q;
   assign pmem_addr   = addr_q;
   assign pmem_wdata  = wdata_q;
   assign i_rdata     = i_line_q;
   assign d_rdata     = d_line_q;
   assign i_resp      = (state_q == ARB_RESP_I);
   assign d_resp      = (state_q == ARB_RESP_D);
   assign i_grant_cnt = i_cnt_q;
   assign d_grant_cnt = d_cnt_q;

   always @(posedge clk) begin
      if (rst_n && (state_q == ARB_IDLE)) begin
         assert (!(d_read && d_write))
            else $warning("d_read and d_write both set; issuing writeback");
      end
   end

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// Bench for cacheline_mem_arbiter: vector table, directed corner sequences, randomized traffic vs model.
module tb_cacheline_mem_arbiter;
   localparam int LW = 256;
   localparam int AW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic [LW-1:0] d_wdata = '0, pmem_rdata = '0;
   logic          pmem_resp = 1'b0;
   logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
   logic          i_resp, d_resp, pmem_read, pmem_write;
   logic [AW-1:0] pmem_addr;
   logic [CW-1:0] i_grant_cnt, d_grant_cnt;

   cacheline_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", nm, got, exp);
      end
   endtask

   // Behavioural memory: unwritten lines read back as the address replicated.
   logic [LW-1:0] mem [logic [AW-1:0]];
   function automatic logic [LW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(a)) return mem[a];
      return {8{a}};
   endfunction

   bit mem_auto = 1'b1;
   int mem_delay = 0;
   int wcnt = 0;
   bit fired = 1'b0;

   // One clock: advance to the falling edge, then play the memory side for this cycle.
   task automatic step();
      @(negedge clk);
      fired = 1'b0;
      if (pmem_resp) pmem_resp = 1'b0;
      else if (mem_auto && (pmem_read || pmem_write)) begin
         if (wcnt >= mem_delay) begin
            pmem_resp = 1'b1;
            fired = 1'b1;
            wcnt = 0;
            if (pmem_write) mem[pmem_addr] = pmem_wdata;
            else pmem_rdata = mem_rd(pmem_addr);
         end else wcnt++;
      end else wcnt = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      pmem_resp = 1'b0; wcnt = 0; fired = 1'b0; mem_auto = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_resp(input bit sd, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!(sd ? d_resp : i_resp) && n < 200);
      chk(sd ? "resp_d_seen" : "resp_i_seen", sd ? d_resp : i_resp, 1);
   endtask

   task automatic wait_op(output int n);
      n = 0;
      while (!(pmem_read || pmem_write) && n < 50) begin
         step();
         n++;
      end
      chk("op_seen", pmem_read | pmem_write, 1);
   endtask

   typedef struct {
      bit            ir, dr, dw;
      logic [AW-1:0] ia, da;
      logic [LW-1:0] line;
      int            dly;
      bit            exp_d, exp_wr;
      logic [AW-1:0] exp_addr;
   } vec_t;
   vec_t tbl[5];

   task automatic apply(input vec_t v);
      int n;
      if (v.exp_wr) d_wdata = v.line;
      else mem[v.exp_addr] = v.line;
      i_read = v.ir; i_addr = v.ia; d_read = v.dr; d_write = v.dw; d_addr = v.da;
      mem_delay = v.dly;
      step();
      chk("tbl_rd", pmem_read, !v.exp_wr);
      chk("tbl_wr", pmem_write, v.exp_wr);
      chk("tbl_addr", pmem_addr, v.exp_addr);
      if (v.exp_wr) chk("tbl_wdata", pmem_wdata, v.line);
      wait_resp(v.exp_d, n);
      chk("tbl_lat", n, v.dly + 1);
      chk("tbl_other_resp", v.exp_d ? i_resp : d_resp, 0);
      if (!v.exp_wr) chk("tbl_rdata", v.exp_d ? d_rdata : i_rdata, v.line);
      i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      step();
      chk("tbl_pulse", i_resp | d_resp, 0);
   endtask

   // Random-phase model state
   bit            pi, pd, dwr, sd, fp, last_d;
   logic [AW-1:0] ai, ad, busy_addr;
   logic [LW-1:0] dwd, busy_wd, line_i, line_d;
   bit            busy_d, busy_wr;
   int            m_st, mi, md;

   initial begin
      int n;
      tbl[0] = '{1, 0, 0, 32'h0000_1000, 32'h0, {32{8'hA5}},          5, 0, 0, 32'h0000_1000};
      tbl[1] = '{0, 1, 0, 32'h0,         32'h0000_2000, {8{32'h1234_5678}}, 0, 1, 0, 32'h0000_2000};
      tbl[2] = '{0, 0, 1, 32'h0,         32'h0000_2040, {16{16'hDEAD}},    2, 1, 1, 32'h0000_2040};
      tbl[3] = '{0, 1, 1, 32'h0,         32'h0000_3000, {8{32'hCAFE_F00D}}, 1, 1, 1, 32'h0000_3000};
      tbl[4] = '{1, 0, 0, 32'h0000_0040, 32'h0, {64{4'h3}},           3, 0, 0, 32'h0000_0040};

      do_reset();
      chk("rst_pmem_read", pmem_read, 0);
      chk("rst_pmem_write", pmem_write, 0);
      chk("rst_pmem_addr", pmem_addr, 0);
      chk("rst_pmem_wdata", pmem_wdata, 0);
      chk("rst_resp", {i_resp, d_resp}, 0);
      chk("rst_rdata", i_rdata | d_rdata, 0);
      chk("rst_cnt", {i_grant_cnt, d_grant_cnt}, 0);

      // Simultaneous reads after reset: D wins the first tie, then I.
      i_read = 1'b1; i_addr = 32'h500; d_read = 1'b1; d_addr = 32'h600; mem_delay = 1;
      step();
      chk("tie_first_addr", pmem_addr, 32'h600);
      wait_resp(1, n);
      chk("tie_d_rdata", d_rdata, mem_rd(32'h600));
      d_read = 1'b0;
      wait_op(n);
      chk("tie_rearb_gap", n, 2);
      chk("tie_second_addr", pmem_addr, 32'h500);
      wait_resp(0, n);
      chk("tie_i_rdata", i_rdata, mem_rd(32'h500));
      i_read = 1'b0;
      step();
      chk("tie_i_cnt", i_grant_cnt, 1);
      chk("tie_d_cnt", d_grant_cnt, 1);

      // Continuous load: D writeback and I read alternate, D first since I was served last.
      i_read = 1'b1; i_addr = 32'h1000; d_write = 1'b1; d_addr = 32'h2040; d_wdata = {16{16'hDEAD}};
      for (int k = 0; k < 4; k++) begin
         wait_op(n);
         chk("alt_addr", pmem_addr, (k % 2 == 0) ? 32'h2040 : 32'h1000);
         chk("alt_write", pmem_write, (k % 2 == 0));
         if (k % 2 == 0) chk("alt_wdata", pmem_wdata, {16{16'hDEAD}});
         wait_resp(k % 2 == 0, n);
      end
      i_read = 1'b0; d_write = 1'b0;
      step(); step();
      chk("alt_cnt", {i_grant_cnt, d_grant_cnt}, {4'd3, 4'd3});

      foreach (tbl[t]) apply(tbl[t]);

      // Requester input changes are ignored while granted.
      d_read = 1'b1; d_addr = 32'h3000; mem_delay = 3;
      step();
      chk("hold_addr0", pmem_addr, 32'h3000);
      d_addr = 32'hFFFF_0000; d_read = 1'b0; d_write = 1'b1;
      step();
      chk("hold_addr1", pmem_addr, 32'h3000);
      chk("hold_op", {pmem_read, pmem_write}, 2'b10);
      wait_resp(1, n);
      chk("hold_rdata", d_rdata, {8{32'hCAFE_F00D}});
      d_write = 1'b0;
      step(); step();
      // Stray memory response while idle.
      mem_auto = 1'b0;
      pmem_resp = 1'b1;
      step();
      chk("stray_resp", {i_resp, d_resp}, 0);
      chk("stray_op", {pmem_read, pmem_write}, 0);
      step();
      chk("stray_resp2", {i_resp, d_resp, pmem_read, pmem_write}, 0);
      mem_auto = 1'b1;
      apply(tbl[4]);

      // Reset in the middle of an I grant.
      i_read = 1'b1; i_addr = 32'h1000; mem_delay = 10;
      step();
      chk("rst_mid_pre", pmem_read, 1);
      #2 rst_n = 1'b0;
      #1 chk("rst_mid_async", pmem_read, 0);
      i_read = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      chk("rst_mid_noresp", {i_resp, d_resp, pmem_read}, 0);
      step();
      chk("rst_mid_noresp2", {i_resp, d_resp, pmem_read}, 0);
      chk("rst_mid_cnt", {i_grant_cnt, d_grant_cnt}, 0);
      apply(tbl[0]);

      // Counter saturation with a 4-bit counter.
      do_reset();
      for (int g = 0; g < 20; g++) begin
         apply('{1, 0, 0, 32'h80, 32'h0, {8{32'h0BAD_BEEF}}, 0, 0, 0, 32'h80});
         if (g == 13) chk("sat_14", i_grant_cnt, 14);
      end
      chk("sat_15", i_grant_cnt, 15);
      chk("sat_d0", d_grant_cnt, 0);

      // Randomized traffic against a transaction-level model.
      do_reset();
      pi = 0; pd = 0; dwr = 0; last_d = 0; m_st = 0; mi = 0; md = 0;
      line_i = '0; line_d = '0; ai = '0; ad = '0; dwd = '0;
      busy_d = 0; busy_wr = 0; busy_addr = '0; busy_wd = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         fp = fired;
         step();
         case (m_st)
            0: if (pi || pd) begin
               sd = (pi && pd) ? !last_d : pd;
               m_st = 1; busy_d = sd; busy_addr = sd ? ad : ai;
               busy_wr = sd & dwr; busy_wd = dwd; last_d = sd;
               if (sd) md = (md < 15) ? md + 1 : md;
               else mi = (mi < 15) ? mi + 1 : mi;
               mem_delay = $urandom_range(0, 4);
            end
            1: if (fp) begin
               m_st = 2;
               if (busy_d) line_d = pmem_rdata; else line_i = pmem_rdata;
            end
            default: m_st = 0;
         endcase
         chk("rnd_excl", pmem_read & pmem_write, 0);
         chk("rnd_read", pmem_read, (m_st == 1) && !busy_wr);
         chk("rnd_write", pmem_write, (m_st == 1) && busy_wr);
         if (m_st == 1) chk("rnd_addr", pmem_addr, busy_addr);
         if (m_st == 1 && busy_wr) chk("rnd_wdata", pmem_wdata, busy_wd);
         chk("rnd_i_resp", i_resp, (m_st == 2) && !busy_d);
         chk("rnd_d_resp", d_resp, (m_st == 2) && busy_d);
         chk("rnd_i_rdata", i_rdata, line_i);
         chk("rnd_d_rdata", d_rdata, line_d);
         chk("rnd_cnt", {i_grant_cnt, d_grant_cnt}, {mi[3:0], md[3:0]});
         if (m_st == 2) begin
            if (busy_d) pd = 0; else pi = 0;
         end
         if (!pi && $urandom_range(0, 2) == 0) begin
            pi = 1; ai = 32'h1000 + ($urandom_range(0, 7) << 6);
         end
         if (!pd && $urandom_range(0, 2) == 0) begin
            pd = 1; ad = 32'h1000 + ($urandom_range(0, 7) << 6);
            dwr = $urandom_range(0, 1); dwd = {8{$urandom}};
         end
         i_read = pi; i_addr = ai;
         d_read = pd & !dwr; d_write = pd & dwr; d_addr = ad; d_wdata = dwd;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog expired");
   end

endmodule
